// File: rtl/i2c_ina219_target_if.sv
// I2C pin bundle between an initiator and the INA219 target emulator.
// SDA is open-drain: sda_in is the resolved line and sda_oe pulls it low.
interface i2c_ina219_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_ina219_target.sv
// I2C target emulating the INA219 register subset (config, bus, current, calibration).
// Optional build macro INA_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
//
// state        | meaning
// S_IDLE       | bus free, waiting for START
// S_ADDR       | shifting in address byte
// S_ADDR_ACK   | driving ACK for a matched address
// S_PTR        | shifting in pointer byte
// S_PTR_ACK    | driving ACK for pointer
// S_WR_MSB     | shifting in data MSB
// S_WR_MSB_ACK | driving ACK for data MSB
// S_WR_LSB     | shifting in data LSB, commits word on last bit
// S_WR_LSB_ACK | driving ACK for data LSB
// S_RD_BYTE    | shifting out a read byte
// S_RD_ACK     | releasing SDA and sampling the initiator ACK/NACK
// S_IGNORE     | not addressed or finished; wait for START/STOP
module i2c_ina219_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h40,
  parameter logic [15:0] CFG_RESET = 16'h399F
) (
  input  logic                      clk,
  input  logic                      reset,
  i2c_ina219_target_if.slave        i2c,
  input  logic [15:0]               current_in,
  input  logic [15:0]               bus_in,
  output logic [15:0]               config_out,
  output logic [15:0]               calib_out,
  output logic                      wr_strobe,
  output logic                      rd_done,
  output logic                      busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WR_MSB, S_WR_MSB_ACK,
    S_WR_LSB, S_WR_LSB_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_q, r_sda_q;
  logic w_scl, w_sda;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= i2c.scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= i2c.sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef INA_TGT_GLITCH_FILTER_EN
  logic [2:0] r_scl_h, r_sda_h;
  logic       r_scl_f, r_sda_f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_h <= 3'b111;
      r_sda_h <= 3'b111;
      r_scl_f <= 1'b1;
      r_sda_f <= 1'b1;
    end else begin
      r_scl_h <= {r_scl_h[1:0], r_scl_s2};
      r_sda_h <= {r_sda_h[1:0], r_sda_s2};
      r_scl_f <= (r_scl_h[0] & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[2]) | (r_scl_h[1] & r_scl_h[2]);
      r_sda_f <= (r_sda_h[0] & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[2]) | (r_sda_h[1] & r_sda_h[2]);
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  // SCL must be high in both samples, so a simultaneous SCL/SDA change is never START/STOP.
  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;

  state_t      r_state, w_state_n;
  logic [2:0]  r_cnt, w_cnt_n;
  logic [6:0]  r_shift, w_shift_n;
  logic        r_sda_oe, w_oe_n;
  logic        r_phase, w_phase_n;
  logic        r_rw, w_rw_n;
  logic        r_ack, w_ack_n;
  logic        r_lsb, w_lsb_n;
  logic [2:0]  r_ptr, w_ptr_n;
  logic [7:0]  r_msb, w_msb_n;
  logic [15:0] r_tx, w_tx_n;
  logic [15:0] r_config, w_config_n;
  logic [15:0] r_calib, w_calib_n;
  logic        r_busy, w_busy_n;
  logic        r_wr_strobe, w_wr_stb_n;
  logic        r_rd_done, w_rd_done_n;
  logic [7:0]  w_byte;
  logic [15:0] w_sel;
  logic        w_bit_state, w_last_rise;

  assign w_byte      = {r_shift, w_sda};
  assign w_last_rise = w_scl_rise & (r_cnt == 3'd0);
  assign w_bit_state = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WR_MSB) ||
                       (r_state == S_WR_LSB) || (r_state == S_RD_BYTE);

  always_comb begin
    w_sel = 16'h0000;
    case (r_ptr)
      3'd0:    w_sel = r_config;
      3'd2:    w_sel = bus_in;
      3'd4:    w_sel = current_in;
      3'd5:    w_sel = r_calib;
      default: w_sel = 16'h0000;
    endcase
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shift_n   = r_shift;
    w_oe_n      = r_sda_oe;
    w_phase_n   = r_phase;
    w_rw_n      = r_rw;
    w_ack_n     = r_ack;
    w_lsb_n     = r_lsb;
    w_ptr_n     = r_ptr;
    w_msb_n     = r_msb;
    w_tx_n      = r_tx;
    w_config_n  = r_config;
    w_calib_n   = r_calib;
    w_busy_n    = r_busy;
    w_wr_stb_n  = 1'b0;
    w_rd_done_n = 1'b0;
    if (w_start) begin
      w_state_n = S_ADDR;
      w_cnt_n   = 3'd7;
      w_oe_n    = 1'b0;
      w_phase_n = 1'b0;
    end else if (w_stop) begin
      w_state_n = S_IDLE;
      w_oe_n    = 1'b0;
      w_phase_n = 1'b0;
      w_busy_n  = 1'b0;
    end else begin
      if (w_scl_rise && w_bit_state) begin
        w_shift_n = w_byte[6:0];
        w_cnt_n   = r_cnt - 3'd1;
      end
      case (r_state)
        S_ADDR: if (w_last_rise) begin
          if (w_byte[7:1] == DEV_ADDR) begin
            w_state_n = S_ADDR_ACK;
            w_rw_n    = w_byte[0];
            w_busy_n  = 1'b1;
          end else begin
            w_state_n = S_IGNORE;
          end
        end
        S_PTR: if (w_last_rise) begin
          w_ptr_n   = w_byte[2:0];
          w_state_n = S_PTR_ACK;
        end
        S_WR_MSB: if (w_last_rise) begin
          w_msb_n   = w_byte;
          w_state_n = S_WR_MSB_ACK;
        end
        S_WR_LSB: if (w_last_rise) begin
          w_state_n = S_WR_LSB_ACK;
          if (r_ptr == 3'd0) begin
            w_config_n = {r_msb, w_byte};
            w_wr_stb_n = 1'b1;
          end else if (r_ptr == 3'd5) begin
            w_calib_n  = {r_msb, w_byte};
            w_wr_stb_n = 1'b1;
          end
        end
        // First fall after the byte drives ACK; the fall ending the ACK clock moves on.
        S_ADDR_ACK, S_PTR_ACK, S_WR_MSB_ACK, S_WR_LSB_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_oe_n    = 1'b1;
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            w_oe_n    = 1'b0;
            case (r_state)
              S_ADDR_ACK: begin
                if (r_rw) begin
                  w_tx_n    = w_sel;
                  w_oe_n    = ~w_sel[15];
                  w_lsb_n   = 1'b0;
                  w_state_n = S_RD_BYTE;
                end else begin
                  w_state_n = S_PTR;
                end
              end
              S_PTR_ACK:    w_state_n = S_WR_MSB;
              S_WR_MSB_ACK: w_state_n = S_WR_LSB;
              default:      w_state_n = S_IGNORE;
            endcase
          end
        end
        S_RD_BYTE: begin
          if (w_last_rise) begin
            w_state_n = S_RD_ACK;
            w_phase_n = 1'b0;
          end
          if (w_scl_fall) begin
            w_tx_n = {r_tx[14:0], 1'b0};
            w_oe_n = ~r_tx[14];
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise && r_phase) w_ack_n = ~w_sda;
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_oe_n    = 1'b0;
              w_tx_n    = {r_tx[14:0], 1'b0};
              w_phase_n = 1'b1;
            end else begin
              w_phase_n   = 1'b0;
              w_rd_done_n = r_lsb;
              if (!r_ack) begin
                w_lsb_n   = 1'b0;
                w_state_n = S_IGNORE;
              end else if (r_lsb) begin
                w_tx_n    = w_sel;
                w_oe_n    = ~w_sel[15];
                w_lsb_n   = 1'b0;
                w_state_n = S_RD_BYTE;
              end else begin
                w_oe_n    = ~r_tx[15];
                w_lsb_n   = 1'b1;
                w_state_n = S_RD_BYTE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd7;
      r_shift     <= 7'd0;
      r_sda_oe    <= 1'b0;
      r_phase     <= 1'b0;
      r_rw        <= 1'b0;
      r_ack       <= 1'b0;
      r_lsb       <= 1'b0;
      r_ptr       <= 3'd0;
      r_msb       <= 8'd0;
      r_tx        <= 16'd0;
      r_config    <= CFG_RESET;
      r_calib     <= 16'd0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_done   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_shift     <= w_shift_n;
      r_sda_oe    <= w_oe_n;
      r_phase     <= w_phase_n;
      r_rw        <= w_rw_n;
      r_ack       <= w_ack_n;
      r_lsb       <= w_lsb_n;
      r_ptr       <= w_ptr_n;
      r_msb       <= w_msb_n;
      r_tx        <= w_tx_n;
      r_config    <= w_config_n;
      r_calib     <= w_calib_n;
      r_busy      <= w_busy_n;
      r_wr_strobe <= w_wr_stb_n;
      r_rd_done   <= w_rd_done_n;
    end
  end

  assign i2c.sda_oe = r_sda_oe;
  assign config_out = r_config;
  assign calib_out  = r_calib;
  assign wr_strobe  = r_wr_strobe;
  assign rd_done    = r_rd_done;
  assign busy       = r_busy;

endmodule
